// File: rtl/bnn_weight_streamer.sv
// Transmit side of the BNN weight-loading link: buffers 8-bit weight words and
// sends each as low nibble then high nibble with a two-cycle load strobe.
// Optional running checksum of sent words: define BNN_STREAM_CHECKSUM_EN.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 20,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic [3:0]       nibble_o,
    output logic             load_en_o,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] neuron_idx,
    output logic [7:0]       checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = FIFO_DEPTH[PTR_W:0];
    localparam logic [IDX_W-1:0] NUM_C   = NUM_NEURONS[IDX_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    typedef enum logic {
        PH_LO,
        PH_HI
    } phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       nibble_q, nibble_d;
    logic             load_en_q, load_en_d;

    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push;
    logic             hi_issue;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign wr_ready = ~fifo_full & (acc_q < NUM_C) & (state_q != DONE);
    assign push     = ena & wr_valid & wr_ready;
    assign hi_issue = ena & (state_q == STREAM) & (phase_q == PH_HI);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        nibble_d  = nibble_q;
        load_en_d = load_en_q;

        if (ena) begin
            if (push) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
                acc_d    = acc_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (phase_q == PH_HI) begin
                        nibble_d  = hold_q[7:4];
                        load_en_d = 1'b1;
                        idx_d     = idx_q + 1'b1;
                        phase_d   = PH_LO;
                    end else if (idx_q == NUM_C) begin
                        // Last high nibble has just been on the bus for its cycle.
                        load_en_d = 1'b0;
                        state_d   = DONE;
                    end else if (!fifo_empty) begin
                        hold_d    = fifo_head;
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        nibble_d  = fifo_head[3:0];
                        load_en_d = 1'b1;
                        phase_d   = PH_HI;
                    end else begin
                        load_en_d = 1'b0;
                    end
                end
                DONE: begin
                    load_en_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= PH_LO;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            nibble_q  <= '0;
            load_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            nibble_q  <= nibble_d;
            load_en_q <= load_en_d;
        end
    end

    // Storage needs no reset: only the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef BNN_STREAM_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (hi_issue) begin
            checksum_d = checksum_q + hold_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_hold_lo;

    assign unused_hold_lo = ^{hold_q[3:0], hi_issue};
    assign checksum       = 8'h00;
`endif

    assign nibble_o   = nibble_q;
    assign load_en_o  = load_en_q;
    assign busy       = (state_q == STREAM);
    assign done       = (state_q == DONE);
    assign neuron_idx = idx_q;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Self-checking bench for bnn_weight_streamer: a nibble-queue model checks every
// strobed nibble, strobe run lengths, enable freezing, terminal DONE and reset.
module tb_bnn_weight_streamer;
  localparam int NUM = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] nibble_o;
  logic       load_en_o;
  logic       busy;
  logic       done;
  logic [4:0] neuron_idx;
  logic [7:0] checksum;

  bnn_weight_streamer #(
    .NUM_NEURONS(NUM),
    .FIFO_DEPTH (4),
    .IDX_W      (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .start     (start),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .nibble_o  (nibble_o),
    .load_en_o (load_en_o),
    .busy      (busy),
    .done      (done),
    .neuron_idx(neuron_idx),
    .checksum  (checksum)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] sess_sum;
  logic [7:0] words[NUM];
  int         n_words;
  bit         spaced = 1'b0;
  logic       ena_edge = 1'b1;
  int         run_len = 0;
  int         last_run = 0;
  logic       prev_le = 1'b0;
  logic [3:0] prev_nib = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- strobe monitor ----------------
  always @(posedge clk) ena_edge <= ena;

  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else if (!ena_edge) begin
      check("freeze_le", load_en_o, prev_le);
      check("freeze_nib", nibble_o, prev_nib);
    end else if (load_en_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", load_en_o, 1'b0);
      end else begin
        check("nibble_stream", nibble_o, exp_q.pop_front());
      end
      run_len++;
    end else if (run_len > 0) begin
      check("run_even", run_len % 2, 0);
      if (spaced) check("run_width2", run_len, 2);
      last_run = run_len;
      run_len = 0;
    end
    prev_le  = load_en_o;
    prev_nib = nibble_o;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [7:0] w);
    bit   ok;
    logic rdy;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = w;
    for (int c = 0; c < 64 && !ok; c++) begin
      rdy = wr_ready;
      tick();
      if (rdy && ena) ok = 1'b1;
    end
    check("handshake", ok, 1'b1);
    if (ok) begin
      exp_q.push_back(w[3:0]);
      exp_q.push_back(w[7:4]);
      sess_sum = sess_sum + w;
      if (n_words < NUM) words[n_words] = w;
      n_words++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_word(input string tag, input int idx);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (neuron_idx == 5'(idx) && load_en_o) hit = 1'b1;
      else tick();
    end
    check(tag, hit, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (done === 1'b1) hit = 1'b1;
      else tick();
    end
    check(tag, hit, 1'b1);
    tick();
  endtask

  task automatic check_session_end(input string tag);
    logic [7:0] exp_ck;
`ifdef BNN_STREAM_CHECKSUM_EN
    exp_ck = sess_sum;
`else
    exp_ck = 8'h00;
`endif
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_le"}, load_en_o, 1'b0);
    check({tag, "_idx"}, neuron_idx, NUM);
    check({tag, "_ready"}, wr_ready, 1'b0);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_checksum"}, checksum, exp_ck);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_le"}, load_en_o, 1'b0);
    check({tag, "_nib"}, nibble_o, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_idx"}, neuron_idx, 5'd0);
    check({tag, "_checksum"}, checksum, 8'h00);
  endtask

  task automatic new_session();
    reset = 1'b1;
    exp_q.delete();
    sess_sum = 8'h00;
    n_words = 0;
    wr_valid = 1'b0;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pre[4];
    logic [7:0] w;
    pre[0] = 8'h7B; pre[1] = 8'h8B; pre[2] = 8'hD1; pre[3] = 8'h00;
    reset = 1'b1; ena = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    sess_sum = 8'h00; n_words = 0;

    // Reset values
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");
    check("idle_ready", wr_ready, 1'b1);

    // Session 1: prefill four words, then start with steady feed
    for (int i = 0; i < 4; i++) send_word(pre[i]);
    wr_valid = 1'b0;
    check("prefill_full_ready", wr_ready, 1'b0);
    check("prefill_not_busy", busy, 1'b0);
    pulse_start();
    check("start_busy", busy, 1'b1);
    check("start_le_lat1", load_en_o, 1'b0);
    tick();
    check("first_le_lat2", load_en_o, 1'b1);
    check("first_nib", nibble_o, 4'hB);
    for (int i = 0; i < NUM - 4; i++) send_word(8'($urandom_range(0, 255)));
    wr_valid = 1'b0;
    check("all_accepted_ready", wr_ready, 1'b0);
    wait_done("s1_done_wait");
    check("s1_run40", last_run, 2 * NUM);
    check_session_end("s1");

    // Surplus write and second start after DONE
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      check("post_done_le", load_en_o, 1'b0);
      check("post_done_ready", wr_ready, 1'b0);
      check("post_done_state", {busy, done}, 2'b01);
      tick();
    end
    wr_valid = 1'b0;
    check("post_done_idx", neuron_idx, NUM);

    // Session 2: reset in the middle of word 10
    new_session();
    pulse_start();
    for (int i = 0; i < 12; i++) send_word(8'($urandom_range(0, 255)));
    wr_valid = 1'b0;
    wait_word("s2_reach_word10", 10);
    #1 reset = 1'b1;
    #1 check_reset_vals("midreset");
    check("midreset_ready", wr_ready, 1'b1);
    exp_q.delete();
    tick();
    reset = 1'b0;
    sess_sum = 8'h00;
    n_words = 0;
    tick();

    // Session 3: sparse feed with an enable freeze in the HI nibble of word 5
    spaced = 1'b1;
    pulse_start();
    for (int i = 0; i < NUM; i++) begin
      w = 8'($urandom_range(0, 255));
      send_word(w);
      wr_valid = 1'b0;
      if (i == 0) begin
        tick();
        check("s3_first_le", load_en_o, 1'b1);
        check("s3_first_nib", nibble_o, w[3:0]);
        check("s3_first_idx", neuron_idx, 5'd0);
      end
      if (i == 5) begin
        wait_word("s3_reach_word5", 5);
        tick();
        check("s3_hi_le", load_en_o, 1'b1);
        check("s3_hi_nib", nibble_o, w[7:4]);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
          tick();
          check("s3_frozen_le", load_en_o, 1'b1);
          check("s3_frozen_nib", nibble_o, w[7:4]);
          check("s3_frozen_idx", neuron_idx, 5'd6);
        end
        ena = 1'b1;
      end
      repeat (4) tick();
    end
    wait_done("s3_done_wait");
    check_session_end("s3");
    spaced = 1'b0;

    // Session 4: all-ones words for the checksum wrap value
    new_session();
    pulse_start();
    for (int i = 0; i < NUM; i++) send_word(8'hFF);
    wr_valid = 1'b0;
    wait_done("s4_done_wait");
    check_session_end("s4");
`ifdef BNN_STREAM_CHECKSUM_EN
    check("s4_checksum_const", checksum, 8'hEC);
`else
    check("s4_checksum_const", checksum, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bnn_weight_streamer.md
Name: bnn_weight_streamer

Overview:
- Transmit side of the BNN weight-loading interface. Takes 8-bit neuron weight words over a valid/ready port and drives the receiver's nibble bus and load-enable strobe.
- Each word is sent as lower nibble then upper nibble, with load-enable high for exactly those two cycles.
- Sits on the loader side of the 20-neuron 8-8-4 BNN core. Streams one full session of NUM_NEURONS words per reset, in neuron-index order.

Parameters:
- NUM_NEURONS, 20, words per session (one per neuron, layer 1 first).
- FIFO_DEPTH, 4, input buffer depth in words (power of 2).
- IDX_W, 5, width of neuron counter; must satisfy 2^IDX_W > NUM_NEURONS.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ena  input  1  global enable; when low, all registers hold (matches receiver gating).
- start  input  1  one-cycle pulse; arms a session; ignored outside IDLE.
- wr_valid  input  1  weight word valid.
- wr_data  input  8  weight word; bit[i] is the weight for input i.
- wr_ready  output  1  = ~fifo_full & (accepted_cnt < NUM_NEURONS) & (state != DONE).
- nibble_o  output  4  nibble bus to receiver (drives uio[7:4]).
- load_en_o  output  1  load strobe to receiver (drives uio[3]).
- busy  output  1  high in STREAM.
- done  output  1  sticky high in DONE.
- neuron_idx  output  IDX_W  index of the word currently or next being sent.
- checksum  output  8  see Optional Feature.

Behaviour:
- Reset values:
  - state=IDLE, FIFO empty, accepted_cnt=0, neuron_idx=0, phase=LO.
  - nibble_o=0, load_en_o=0, busy=0, done=0, checksum=0.
- ena=0 at an edge: no register changes, including FIFO push/pop and outputs; wr_ready still reflects FIFO state, but no push occurs.
- Push: on an edge with ena & wr_valid & wr_ready; accepted_cnt increments. Push is allowed in IDLE and STREAM (prefill permitted).
- FSM transitions (all require ena=1):
  - IDLE: start -> STREAM. start and push in the same cycle are both honoured.
  - STREAM, phase LO, FIFO non-empty:
    - Pop word into hold register.
    - Registered outputs next cycle: load_en_o=1, nibble_o=word[3:0]. phase->HI.
  - STREAM, phase HI:
    - Registered outputs next cycle: load_en_o=1, nibble_o=hold[7:4].
    - neuron_idx increments after this cycle; phase->LO.
  - STREAM, phase LO, FIFO empty (underrun): load_en_o<=0, wait. Gaps occur only between words, never between the two nibbles.
  - After the HI cycle of word NUM_NEURONS-1: load_en_o<=0, state->DONE, done<=1, busy<=0.
- Back-to-back: if the FIFO is non-empty at each LO decision, load_en_o stays high continuously. With a prefilled FIFO and steady input, a session is 2*NUM_NEURONS cycles (40) of strobe.
- Latency: first load_en_o=1 cycle begins 2 edges after the start edge if the FIFO is non-empty.
- DONE is terminal until reset. The receiver's neuron pointer only clears on reset, so a second session is not permitted: start is ignored and wr_ready=0.
- Reset mid-session: immediate return to reset values; load_en_o drops asynchronously. Receiver shares the reset, so both ends realign.
- neuron_idx never exceeds NUM_NEURONS; it equals NUM_NEURONS in DONE.
- Surplus wr_valid beyond NUM_NEURONS accepted words is back-pressured forever (wr_ready=0).

Optional Feature:
- Macro BNN_STREAM_CHECKSUM_EN.
- Defined: checksum accumulates the 8-bit modulo-256 sum of every word on the edge its HI nibble is issued; it holds in DONE, for host readback comparison.
- Undefined: checksum tied to 0, no accumulator logic.

Test Plan:
- Prefill 4 words 0x7B,0x8B,0xD1,0x00, then pulse start with steady feed of the remaining 16 -> nibble_o sequence B,7,B,8,1,D,0,0,..., load_en_o high 40 consecutive cycles, done=1 afterwards, neuron_idx=20.
- Feed one word every 5 cycles -> load_en_o pulses are exactly 2 cycles wide per word, low gaps between words, never a single-cycle pulse.
- Drop ena for 3 cycles while in phase HI of word 5 -> outputs frozen (load_en_o stays 1, nibble_o=upper nibble), resumes with no duplicated or skipped nibble.
- Attempt a 21st write and a second start after DONE -> wr_ready=0, start ignored, load_en_o stays 0.
- Assert reset during word 10 -> all outputs 0 immediately; a new session after release starts at neuron_idx=0 with the lower nibble.
- With BNN_STREAM_CHECKSUM_EN, 20 words all 0xFF -> checksum=0xEC; without the macro, checksum=0.
